// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Definitions shared by the UART transmit and receive paths.
//   - uart_state_t : frame FSM states. The receiver uses the same encoding,
//                    so a single checker can follow either side.
//   - OVERSAMPLE   : s_tick pulses per bit period.
//   - cnt_width    : counter width for a terminal count, with a lower bound.
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int OVERSAMPLE = 16;

    // Width needed to count 0..(count-1). The result is never below min_w,
    // so a short stop period still leaves room for the 0..15 bit count.
    function automatic int cnt_width(input int count, input int min_w);
        int w;
        w = $clog2(count);
        if (w < min_w) begin
            w = min_w;
        end
        return w;
    endfunction

endpackage : uart_pkg

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
//   UART serial transmitter. A parallel word is framed as one start bit
//   (low), DBIT data bits LSB-first and a stop period (high) that lasts
//   SB_TICK s_tick pulses. Bit timing comes from the shared oversampling
//   strobe s_tick, which pulses OVERSAMPLE times per bit period.
//
// Parameters
//   DBIT         data bits per frame (default 8)
//   SB_TICK      stop-period length in s_tick pulses (16/24/32 = 1/1.5/2)
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   synchronous, active-high
//   s_tick       in   baud oversampling strobe, one clk wide
//   tx_start     in   send request, only looked at in IDLE
//   din          in   data word, captured when tx_start is accepted
//   tx_busy      out  high in every state except IDLE (registered)
//   tx_done_tick out  one-clk pulse at the end of the stop period
//   tx           out  serial line, registered, idles high
//
// Handshake: tx_start acts as a valid with tx_busy as its inverted ready.
// A request is taken on any rising edge where the FSM is in IDLE
// (tx_busy low), and din is captured on that same edge. A request while
// busy is dropped, not queued. Holding tx_start high through tx_done_tick
// starts the next frame one clk later.
//
// Observation: state_q holds the current FSM state as a uart_state_t.
// ---------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            tx_start,
    input  logic [DBIT-1:0] din,
    output logic            tx_busy,
    output logic            tx_done_tick,
    output logic            tx
);

    // Tick counter: it counts the 16 ticks of a data bit and the SB_TICK
    // ticks of the stop period, so it needs at least 4 bits.
    localparam int SW = cnt_width(SB_TICK, 4);
    // Bit counter: counts 0..DBIT-1. It needs at least 1 bit so DBIT=1
    // still gives a legal vector.
    localparam int NW = cnt_width(DBIT, 1);

    localparam logic [SW-1:0] S_BIT_LAST  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

    uart_state_t     state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            tx_q, tx_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // The start does not wait for s_tick. A tick that arrives
                // on the accepting edge is not counted.
                if (tx_start) begin
                    b_d     = din;
                    s_d     = '0;
                    state_d = START;
                end
            end

            START: begin
                if (s_tick) begin
                    if (s_q == S_BIT_LAST) begin
                        s_d     = '0;
                        n_d     = '0;
                        state_d = DATA;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end

            DATA: begin
                if (s_tick) begin
                    if (s_q == S_BIT_LAST) begin
                        s_d = '0;
                        b_d = b_q >> 1;
                        if (n_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end

            STOP: begin
                if (s_tick) begin
                    if (s_q == S_STOP_LAST) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode from the next state. The line level and tx_busy are
    // registered together with the state, so they change on the same edge
    // as the state. In DATA, b_d[0] is the bit for the next period, which
    // already reflects the shift that happens at the bit boundary.
    // ------------------------------------------------------------------
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = b_d[0];
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    // ------------------------------------------------------------------
    // State register with synchronous reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign tx           = tx_q;
    assign tx_done_tick = done_q;
    assign tx_busy      = busy_q;

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx
//   Bench for uart_tx. Instance A uses the defaults (DBIT=8, SB_TICK=16).
//   Instance B uses DBIT=7, SB_TICK=32. s_tick pulses once every 4 clks.
//   When a frame is started, the expected line levels (start, data, stop)
//   are pushed to exp_q. The frame receiver pops one level per bit period
//   and checks that the line holds it for the whole period.
// ---------------------------------------------------------------------------
module tb_uart_tx;

  logic clk;
  logic reset;
  logic s_tick;

  logic       tx_start_a, tx_busy_a, tx_done_a, tx_a;
  logic [7:0] din_a;
  logic       tx_start_b, tx_busy_b, tx_done_b, tx_b;
  logic [6:0] din_b;

  // Selects which instance the frame receiver watches.
  logic sel_b;
  logic m_tx, m_busy, m_done;
  assign m_tx   = sel_b ? tx_b      : tx_a;
  assign m_busy = sel_b ? tx_busy_b : tx_busy_a;
  assign m_done = sel_b ? tx_done_b : tx_done_a;

  int n_checks;
  int n_fail;

  logic [0:0] exp_q[$];

  typedef struct {
    logic [7:0] din;
    logic [9:0] seq;   // line levels in send order, bit 0 is sent first
  } vec_t;

  vec_t vecs[4];

  uart_tx #(.DBIT(8), .SB_TICK(16)) dut_a (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .tx_start     (tx_start_a),
    .din          (din_a),
    .tx_busy      (tx_busy_a),
    .tx_done_tick (tx_done_a),
    .tx           (tx_a)
  );

  uart_tx #(.DBIT(7), .SB_TICK(32)) dut_b (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .tx_start     (tx_start_b),
    .din          (din_b),
    .tx_busy      (tx_busy_b),
    .tx_done_tick (tx_done_b),
    .tx           (tx_b)
  );

  // ---------------- clock / tick ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    int div;
    div = 0;
    s_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      div = (div + 1) % 4;
      s_tick = (div == 0);
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic push_seq(input logic [9:0] seq, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      exp_q.push_back(seq[i]);
    end
  endtask

  task automatic start_a(input logic [7:0] d);
    @(posedge clk);
    #1;
    din_a      = d;
    tx_start_a = 1'b1;
    @(posedge clk);
    #1;
    tx_start_a = 1'b0;
  endtask

  // Receives one frame from the selected instance. It pops dbit+2 levels
  // from exp_q, counts s_tick pulses, and checks tx_done_tick, tx_busy and
  // tx one edge after the last stop tick is consumed. On return it is
  // #1 after that edge.
  task automatic recv_frame(input string name, input int dbit, input int sb);
    int         total, t, bitidx, guard;
    logic [0:0] exp_bit;
    bit         lvl_bad, busy_bad, done_bad, timed_out;
    total     = 16 * (1 + dbit) + sb;
    guard     = 0;
    timed_out = 1'b0;
    @(negedge clk);
    while (m_tx !== 1'b0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check({name, "_start_seen"}, {31'd0, m_tx}, 32'd0);
    if (m_tx !== 1'b0) begin
      exp_q.delete();
      return;
    end
    check({name, "_exp_depth"}, exp_q.size(), dbit + 2);
    if (exp_q.size() != dbit + 2) begin
      exp_q.delete();
      return;
    end
    exp_bit  = exp_q.pop_front();
    t        = 0;
    bitidx   = 0;
    guard    = 0;
    lvl_bad  = 1'b0;
    busy_bad = 1'b0;
    done_bad = 1'b0;
    while (t < total) begin
      if (m_tx !== exp_bit) lvl_bad = 1'b1;
      if (m_busy !== 1'b1) busy_bad = 1'b1;
      if (m_done !== 1'b0) done_bad = 1'b1;
      if (s_tick) begin
        t++;
        if (t == total) break;
        if (bitidx <= dbit && t == 16 * (bitidx + 1)) begin
          check($sformatf("%s_bit%0d", name, bitidx), {31'd0, lvl_bad}, 32'd0);
          bitidx++;
          exp_bit = exp_q.pop_front();
          lvl_bad = 1'b0;
        end
      end
      @(negedge clk);
      guard++;
      if (guard > total * 4 + 50) begin
        timed_out = 1'b1;
        break;
      end
    end
    check({name, "_timeout"}, {31'd0, timed_out}, 32'd0);
    if (timed_out) begin
      exp_q.delete();
      return;
    end
    check({name, "_stop_level"}, {31'd0, lvl_bad}, 32'd0);
    check({name, "_busy_in_frame"}, {31'd0, busy_bad}, 32'd0);
    check({name, "_early_done"}, {31'd0, done_bad}, 32'd0);
    @(posedge clk);
    #1;
    check({name, "_done_pulse"}, {31'd0, m_done}, 32'd1);
    check({name, "_busy_end"}, {31'd0, m_busy}, 32'd0);
    check({name, "_tx_end"}, {31'd0, m_tx}, 32'd1);
  endtask

  // ---------------- test ----------------
  initial begin
    bit bad;
    n_checks   = 0;
    n_fail     = 0;
    sel_b      = 1'b0;
    reset      = 1'b1;
    tx_start_a = 1'b0;
    tx_start_b = 1'b0;
    din_a      = 8'h00;
    din_b      = 7'h00;

    vecs[0] = '{din: 8'hA5, seq: 10'b1101001010};
    vecs[1] = '{din: 8'h81, seq: 10'b1100000010};
    vecs[2] = '{din: 8'h3C, seq: 10'b1001111000};
    vecs[3] = '{din: 8'h5A, seq: 10'b1010110100};

    // Reset state
    @(posedge clk);
    #1;
    check("rst_tx", {31'd0, tx_a}, 32'd1);
    check("rst_busy", {31'd0, tx_busy_a}, 32'd0);
    check("rst_done", {31'd0, tx_done_a}, 32'd0);
    check("rst_tx_b", {31'd0, tx_b}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);

    // Table-driven single frames
    for (int i = 0; i < 4; i++) begin
      push_seq(vecs[i].seq, 10);
      start_a(vecs[i].din);
      recv_frame($sformatf("vec%0d", i), 8, 16);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_done_single", i), {31'd0, tx_done_a}, 32'd0);
      repeat (5) @(posedge clk);
    end

    // Start request during a frame is ignored
    push_seq(10'b1101001010, 10);
    start_a(8'hA5);
    fork
      recv_frame("ignored", 8, 16);
      begin
        repeat (200) @(posedge clk);
        #1;
        din_a      = 8'h3C;
        tx_start_a = 1'b1;
        @(posedge clk);
        #1;
        tx_start_a = 1'b0;
      end
    join
    bad = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || tx_busy_a !== 1'b0) bad = 1'b1;
    end
    check("ignored_no_2nd_frame", {31'd0, bad}, 32'd0);

    // Back-to-back frames with tx_start held high
    @(posedge clk);
    #1;
    din_a      = 8'h00;
    tx_start_a = 1'b1;
    push_seq(10'b1000000000, 10);
    @(posedge clk);
    #1;
    din_a = 8'hFF;
    recv_frame("b2b_00", 8, 16);
    @(posedge clk);
    #1;
    check("b2b_gap_tx", {31'd0, tx_a}, 32'd0);
    check("b2b_gap_busy", {31'd0, tx_busy_a}, 32'd1);
    tx_start_a = 1'b0;
    push_seq(10'b1111111110, 10);
    recv_frame("b2b_ff", 8, 16);
    repeat (5) @(posedge clk);

    // din changed one clk after capture
    push_seq(10'b1110000110, 10);
    @(posedge clk);
    #1;
    din_a      = 8'hC3;
    tx_start_a = 1'b1;
    @(posedge clk);
    #1;
    tx_start_a = 1'b0;
    din_a      = 8'h00;
    recv_frame("din_change", 8, 16);
    repeat (5) @(posedge clk);

    // Instance B: DBIT=7, SB_TICK=32
    sel_b = 1'b1;
    push_seq(10'b0110101010, 9);
    @(posedge clk);
    #1;
    din_b      = 7'h55;
    tx_start_b = 1'b1;
    @(posedge clk);
    #1;
    tx_start_b = 1'b0;
    recv_frame("param", 7, 32);
    sel_b = 1'b0;
    repeat (5) @(posedge clk);

    // Reset in the middle of DATA
    start_a(8'h3C);
    repeat (120) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_tx", {31'd0, tx_a}, 32'd1);
    check("midrst_busy", {31'd0, tx_busy_a}, 32'd0);
    check("midrst_done", {31'd0, tx_done_a}, 32'd0);
    bad = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (tx_a !== 1'b1 || tx_busy_a !== 1'b0 || tx_done_a !== 1'b0) bad = 1'b1;
    end
    reset = 1'b0;
    repeat (800) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || tx_busy_a !== 1'b0 || tx_done_a !== 1'b0) bad = 1'b1;
    end
    check("midrst_quiet", {31'd0, bad}, 32'd0);

    // A full frame after the reset
    push_seq(10'b1101001010, 10);
    start_a(8'hA5);
    recv_frame("post_rst", 8, 16);
    repeat (5) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_uart_tx
